// File: rtl/lfsr_prbs_checker_if.sv
// Word stream and status bundle between an LFSR pattern source and lfsr_prbs_checker.
// The master side feeds words and clears; the slave side (the checker) reports lock and error status.
interface lfsr_prbs_checker_if #(
  parameter int NUM_BITS  = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 i_Valid;
  logic [NUM_BITS-1:0]  i_Data;
  logic                 i_Clear_Err;
  logic                 o_Locked;
  logic                 o_Err;
  logic [ERR_CNT_W-1:0] o_Err_Count;
  logic                 o_Lock_Lost;

  modport master (
    output i_Valid, i_Data, i_Clear_Err,
    input  o_Locked, o_Err, o_Err_Count, o_Lock_Lost
  );

  modport slave (
    input  i_Valid, i_Data, i_Clear_Err,
    output o_Locked, o_Err, o_Err_Count, o_Lock_Lost
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising checker for the XNOR-feedback LFSR word stream: seeds from received words,
// locks after a run of correct predictions, then flywheels and counts mismatched words.
module lfsr_prbs_checker #(
  parameter int NUM_BITS    = 8,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  lfsr_prbs_checker_if.slave   i_Bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  // Tap sets of the generator, as a bit mask over the word (tap t -> bit t-1).
  function automatic logic [31:0] f_taps(input int n);
    case (n)
      3:  f_taps = 32'h0000_0006;
      4:  f_taps = 32'h0000_000C;
      5:  f_taps = 32'h0000_0014;
      6:  f_taps = 32'h0000_0030;
      7:  f_taps = 32'h0000_0060;
      8:  f_taps = 32'h0000_00B8;
      9:  f_taps = 32'h0000_0110;
      10: f_taps = 32'h0000_0240;
      11: f_taps = 32'h0000_0500;
      12: f_taps = 32'h0000_0829;
      13: f_taps = 32'h0000_100D;
      14: f_taps = 32'h0000_2015;
      15: f_taps = 32'h0000_6000;
      16: f_taps = 32'h0000_D008;
      17: f_taps = 32'h0001_2000;
      18: f_taps = 32'h0002_0400;
      19: f_taps = 32'h0004_0023;
      20: f_taps = 32'h0009_0000;
      21: f_taps = 32'h0014_0000;
      22: f_taps = 32'h0030_0000;
      23: f_taps = 32'h0042_0000;
      24: f_taps = 32'h00E1_0000;
      25: f_taps = 32'h0120_0000;
      26: f_taps = 32'h0200_0023;
      27: f_taps = 32'h0400_0013;
      28: f_taps = 32'h0900_0000;
      29: f_taps = 32'h1400_0000;
      30: f_taps = 32'h2000_0029;
      31: f_taps = 32'h4800_0000;
      32: f_taps = 32'h8020_0003;
      default: f_taps = 32'h0000_0006;
    endcase
  endfunction

  localparam logic [31:0]         TAPS = f_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] MASK = TAPS[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] ALL1 = '1;

  // Shift left, XNOR of taps enters at bit 0; all-ones maps to itself.
  function automatic logic [NUM_BITS-1:0] f_next(input logic [NUM_BITS-1:0] w);
    f_next = {w[NUM_BITS-2:0], ~^(w & MASK)};
  endfunction

  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_t;

  state_t               r_State;
  logic [NUM_BITS-1:0]  r_Exp;
  logic [GW-1:0]        r_Good;
  logic [BW-1:0]        r_Bad;
  logic                 r_Locked;
  logic                 r_Err;
  logic [ERR_CNT_W-1:0] r_Cnt;
  logic                 r_Lock_Lost;
  logic [NUM_BITS-1:0]  w_D;

  assign w_D = i_Bus.i_Data;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= S_SEARCH;
      r_Exp       <= '0;
      r_Good      <= '0;
      r_Bad       <= '0;
      r_Locked    <= 1'b0;
      r_Err       <= 1'b0;
      r_Cnt       <= '0;
      r_Lock_Lost <= 1'b0;
    end else begin
      r_Err <= 1'b0;
      if (i_Bus.i_Valid) begin
        case (r_State)
          S_SEARCH: begin
            if (w_D != ALL1) begin
              r_Exp   <= f_next(w_D);
              r_Good  <= '0;
              r_State <= S_VERIFY;
            end
          end
          S_VERIFY: begin
            r_Exp <= f_next(w_D);
            if (w_D == r_Exp) begin
              r_Good <= r_Good + 1'b1;
              if (r_Good == GW'(LOCK_COUNT - 1)) begin
                r_State  <= S_LOCKED;
                r_Locked <= 1'b1;
                r_Bad    <= '0;
              end
            end else begin
              r_Good <= '0;
              if (w_D == ALL1) r_State <= S_SEARCH;
            end
          end
          S_LOCKED: begin
            // Flywheel: prediction runs on its own, never reseeded from the data.
            r_Exp <= f_next(r_Exp);
            if (w_D == r_Exp) begin
              r_Bad <= '0;
            end else begin
              r_Err <= 1'b1;
              if (r_Cnt != '1) r_Cnt <= r_Cnt + 1'b1;
              if (r_Bad == BW'(UNLOCK_ERRS - 1)) begin
                r_State     <= S_SEARCH;
                r_Locked    <= 1'b0;
                r_Bad       <= '0;
                r_Lock_Lost <= 1'b1;
              end else begin
                r_Bad <= r_Bad + 1'b1;
              end
            end
          end
          default: begin
            r_State  <= S_SEARCH;
            r_Locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over a same-cycle count/sticky update.
      if (i_Bus.i_Clear_Err) begin
        r_Cnt       <= '0;
        r_Lock_Lost <= 1'b0;
      end
    end
  end

  assign i_Bus.o_Locked    = r_Locked;
  assign i_Bus.o_Err       = r_Err;
  assign i_Bus.o_Err_Count = r_Cnt;
  assign i_Bus.o_Lock_Lost = r_Lock_Lost;

endmodule

// File: doc/lfsr_prbs_checker.md
Name: lfsr_prbs_checker

Overview:
- Downstream consumer of the team's LFSR block: receives its o_LFSR_Data word stream, self-synchronises to it, and checks every subsequent word against a locally predicted sequence.
- Used in link/loopback benches and on hardware to qualify data paths carrying LFSR pattern traffic.
- Reports lock status, per-word error pulses, a saturating error count and a sticky lock-lost flag.

Parameters:
- NUM_BITS, 8, word width; must equal NUM_BITS of the LFSR generator feeding it (3..32).
- LOCK_COUNT, 16, consecutive correctly predicted words required to declare lock (>=1).
- UNLOCK_ERRS, 4, consecutive mismatching words while locked that drop lock (>=1).
- ERR_CNT_W, 16, width of error counter.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_Valid  in  1  i_Data carries a word this cycle; no backpressure.
- i_Data  in  NUM_BITS  received LFSR word.
- i_Clear_Err  in  1  clears o_Err_Count and o_Lock_Lost.
- o_Locked  out  1  high in LOCKED state.
- o_Err  out  1  one-cycle pulse: a locked-state word mismatched.
- o_Err_Count  out  ERR_CNT_W  saturating count of mismatched words while locked.
- o_Lock_Lost  out  1  sticky: lock dropped since last clear/reset.

Behaviour:
- One clock (i_Clk); reset is synchronous and active-high (i_Rst).
- next(w): one-step successor of word w under the team LFSR block's XNOR feedback for NUM_BITS; implement by instantiating that LFSR block or an identical feedback function. All-ones is the XNOR lockup word (next(all-ones) = all-ones).
- Reset: state=SEARCH, expected=0, good_cnt=0, bad_run=0, o_Locked=0, o_Err=0, o_Err_Count=0, o_Lock_Lost=0.
- Cycles with i_Valid=0: no state, counter or expected change; o_Err=0.
- SEARCH, valid word d: if d==all-ones stay SEARCH; else expected<=next(d), good_cnt<=0, go VERIFY.
- VERIFY, valid d: match (d==expected): good_cnt++, expected<=next(d); when good_cnt reaches LOCK_COUNT go LOCKED. Mismatch: reseed expected<=next(d), good_cnt<=0, stay VERIFY (all-ones d -> SEARCH). No o_Err in VERIFY.
- LOCKED, valid d: expected<=next(expected) always (flywheel, not reseeded from d). Match: bad_run<=0. Mismatch: o_Err=1 next cycle, o_Err_Count++ (saturates at all-ones), bad_run++; when bad_run reaches UNLOCK_ERRS go SEARCH, bad_run<=0, o_Lock_Lost<=1.
- Latency: all outputs registered; o_Err/o_Locked/count update on the edge after the clock that sampled the word.
- Lock time with continuous valid clean stream: o_Locked rises 1+LOCK_COUNT valid words after first word.
- i_Clear_Err: o_Err_Count<=0, o_Lock_Lost<=0; priority over same-cycle increment/set (that event not counted; o_Err still pulses, state transition still taken).
- i_Rst mid-operation: return to reset values next edge regardless of other inputs.
- Only full-word equality checked; no bit-error counting.

Test Plan:
- NUM_BITS=3, LOCK_COUNT=4, UNLOCK_ERRS=2; LFSR generator seed 0, enable continuous, i_Valid=1 -> o_Locked=1 after 5th word, o_Err never pulses, o_Err_Count=0 over 100 words.
- Locked, flip bit0 of one word -> single o_Err pulse, o_Err_Count=1, o_Locked stays 1; following clean words match (flywheel), no further errors.
- Locked, corrupt 2 consecutive words -> o_Err pulses twice, count=2, o_Locked=0, o_Lock_Lost=1; clean stream relocks after 5 words, o_Lock_Lost stays 1 until i_Clear_Err.
- Constant all-ones input for 20 words -> state stays SEARCH, o_Locked=0, count=0.
- Clean stream with i_Valid toggling 1,0,0,1,... -> locks after 5 valid words; gaps cause no errors.
- Force count to saturate (ERR_CNT_W=2): 5 isolated errors -> count holds 3; assert i_Clear_Err same cycle as an error -> count=0, o_Err pulses, o_Lock_Lost=0; i_Rst while locked -> all outputs 0 next edge.
